// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the per-boundary payload layouts (MEM/WB shown here), the skid
// buffer state encoding and a small helper used by the stage register.
// Stage wrappers pack and unpack their fields using the offsets below.
package pipe_pkg;

  // MEM/WB payload layout, LSB first: m2reg, wreg, rn, alu, mo
  localparam int unsigned MW_M2REG_BIT = 0;
  localparam int unsigned MW_WREG_BIT  = 1;
  localparam int unsigned MW_RN_LSB    = 2;
  localparam int unsigned MW_RN_W      = 5;
  localparam int unsigned MW_ALU_LSB   = MW_RN_LSB + MW_RN_W;
  localparam int unsigned MW_ALU_W     = 32;
  localparam int unsigned MW_MO_LSB    = MW_ALU_LSB + MW_ALU_W;
  localparam int unsigned MW_MO_W      = 32;
  localparam int unsigned MW_WIDTH     = MW_MO_LSB + MW_MO_W;  // 71

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

  // The stage can take another word unless both entries are occupied.
  function automatic logic skid_can_accept(input skid_state_t s);
    return (s != S_FULL);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bus around one pipeline stage register.
//   in_valid/in_data/in_ready    : upstream side of the stage
//   out_valid/out_data/out_ready : downstream side of the stage
// slave  : view taken by the stage register itself
// master : view taken by the surrounding stages (or a bench)
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = MW_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter.
//   clk : rising-edge clock
//   clr : synchronous clear, highest priority
//   inc : count enable; the counter holds at all-ones
//   q   : current count
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready flow control.
// Ports:
//   clk       : rising-edge clock
//   clrn      : synchronous active-high reset
//   flush     : drop every held entry (data registers keep their contents)
//   bus       : payload handshake bus (slave view), see pipe_stage_reg_if
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
// Build option PIPE_STAGE_SKID_EN: when defined, a 2-entry skid buffer with
// a registered in_ready; otherwise a single entry whose in_ready is
// combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = MW_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             out_valid_q;
  logic [WIDTH-1:0] main_q;
  logic             in_ready_w;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.in_valid && in_ready_w;
  assign out_xfer = out_valid_q && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_d;
  logic             in_ready_d;

  assign in_ready_w = in_ready_q;

  // State register; out_valid and in_ready are flopped from the next state
  // so that in_ready has no path from out_ready.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (in_xfer) state_d = S_ONE;
        S_ONE: begin
          if (in_xfer && !out_xfer)      state_d = S_FULL;
          else if (!in_xfer && out_xfer) state_d = S_EMPTY;
        end
        S_FULL:  if (out_xfer) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = skid_can_accept(state_d);
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (!flush) begin
      unique case (state_q)
        S_EMPTY: if (in_xfer) main_q <= bus.in_data;
        S_ONE: begin
          if (in_xfer && out_xfer) main_q <= bus.in_data;
          else if (in_xfer)        skid_q <= bus.in_data;
        end
        S_FULL:  if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end
`else
  assign in_ready_w = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (clrn) begin
      out_valid_q <= 1'b0;
      main_q      <= RESET_VAL;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      main_q      <= bus.in_data;
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;

  pipe_sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (clrn),
    .inc (out_valid_q && !bus.out_ready),
    .q   (stall_cnt)
  );

endmodule
